// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: REQ/HOLD handshake, PC update, HALT/resume
// Optional fetch timeout with ERR state enabled by macro FETCH_TIMEOUT_EN.
module fetch_sequencer #(
   parameter logic [7:0] RESET_PC       = 8'h00,
   parameter int         TIMEOUT_CYCLES = 15
) (
   input  logic       clk,
   input  logic       reset,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_data,
   output logic [7:0] ir,
   output logic       ir_valid,
   input  logic       ir_ready,
   input  logic       pc_load,
   input  logic [7:0] pc_target,
   output logic [7:0] pc,
   output logic       halted,
   input  logic       resume,
   output logic       fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_HALT,
      S_ERR
   } state_t;

   state_t     state, state_next;
   logic [7:0] pc_next;
   logic [7:0] ir_next;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("fetch_sequencer: TIMEOUT_CYCLES must be 1..255");
   end

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
   logic [7:0] tcnt, tcnt_next;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         ir    <= 8'h00;
`ifdef FETCH_TIMEOUT_EN
         tcnt  <= 8'h00;
`endif
      end else begin
         state <= state_next;
         pc    <= pc_next;
         ir    <= ir_next;
`ifdef FETCH_TIMEOUT_EN
         tcnt  <= tcnt_next;
`endif
      end
   end

   // Every transition into S_REQ restarts the ack wait counter.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      ir_next    = ir;
`ifdef FETCH_TIMEOUT_EN
      tcnt_next  = tcnt;
`endif
      case (state)
         S_IDLE: begin
            state_next = S_REQ;
`ifdef FETCH_TIMEOUT_EN
            tcnt_next  = 8'h00;
`endif
         end
         S_REQ: begin
            if (imem_ack) begin
               ir_next    = imem_data;
               state_next = S_HOLD;
            end
`ifdef FETCH_TIMEOUT_EN
            else begin
               tcnt_next = tcnt + 8'd1;
               if (tcnt + 8'd1 == TIMEOUT_LIMIT) begin
                  state_next = S_ERR;
               end
            end
`endif
         end
         S_HOLD: begin
            if (ir_ready) begin
               if (ir[7:4] == 4'hF) begin
                  state_next = S_HALT;
               end else begin
                  pc_next    = pc_load ? pc_target : pc + 8'd1;
                  state_next = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                  tcnt_next  = 8'h00;
`endif
               end
            end
         end
         S_HALT: begin
            if (resume) begin
               pc_next    = pc + 8'd1;
               state_next = S_REQ;
`ifdef FETCH_TIMEOUT_EN
               tcnt_next  = 8'h00;
`endif
            end
         end
         S_ERR: begin
            state_next = S_ERR;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign imem_req  = (state == S_REQ);
   assign imem_addr = pc;
   assign ir_valid  = (state == S_HOLD);
   assign halted    = (state == S_HALT);
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err = (state == S_ERR);
`else
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a program-counter reference model
module tb_fetch_sequencer;

   localparam logic [7:0] RST_PC = 8'h00;
   localparam int         TOUT   = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_data = 8'h00;
   logic [7:0] ir;
   logic       ir_valid;
   logic       ir_ready = 1'b0;
   logic       pc_load = 1'b0;
   logic [7:0] pc_target = 8'h00;
   logic [7:0] pc;
   logic       halted;
   logic       resume = 1'b0;
   logic       fetch_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] addr_q[$];
   logic [7:0] ir_q[$];
   logic [7:0] model_pc;
   logic [7:0] cur_addr = 8'h00;
   logic       req_d = 1'b0;

   fetch_sequencer #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TOUT)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .pc_load(pc_load), .pc_target(pc_target), .pc(pc),
      .halted(halted), .resume(resume), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the expected fetch address on each request rise and the expected opcode on acceptance.
   always @(negedge clk) begin
      if (imem_req && !req_d) begin
         if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_request actual addr=%0h expected no request", imem_addr);
         end else begin
            cur_addr = addr_q.pop_front();
         end
      end
      if (imem_req) chk("imem_addr", imem_addr, cur_addr);
      chk("req_valid_exclusive", imem_req & ir_valid, 0);
      if (ir_valid) begin
         if (ir_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ir_valid actual ir=%0h expected no valid", ir);
         end else begin
            chk("ir_value", ir, ir_q[0]);
            if (ir_ready) void'(ir_q.pop_front());
         end
      end
      req_d = imem_req;
   end

   task automatic fetch_one(input logic [7:0] op, input int ack_dly, input int rdy_dly,
                            input logic ld, input logic [7:0] tgt, input int halt_dly);
      int n;
      addr_q.push_back(model_pc);
      ir_q.push_back(op);
      n = 0;
      while (!imem_req && n < 50) begin
         step();
         n++;
      end
      if (!imem_req) begin
         checks++;
         errors++;
         $display("FAIL request_wait actual imem_req=0 expected 1 within 50 cycles");
      end
      for (int i = 0; i < ack_dly; i++) begin
         imem_data = 8'($urandom);
         pc_load   = 1'($urandom);
         pc_target = 8'($urandom);
         step();
      end
      imem_ack  = 1'b1;
      imem_data = op;
      step();
      imem_ack = 1'b0;
      pc_load  = 1'b0;
      chk("ir_valid_latency", ir_valid, 1);
      for (int i = 0; i < rdy_dly; i++) begin
         imem_data = 8'($urandom);
         imem_ack  = 1'($urandom);
         pc_load   = 1'($urandom);
         pc_target = 8'($urandom);
         chk("hold_no_req", imem_req, 0);
         step();
      end
      ir_ready  = 1'b1;
      pc_load   = ld;
      pc_target = tgt;
      step();
      ir_ready = 1'b0;
      pc_load  = 1'b0;
      imem_ack = 1'b0;
      chk("valid_drop", ir_valid, 0);
      if (op[7:4] == 4'hF) begin
         for (int i = 0; i < halt_dly; i++) begin
            chk("halted", halted, 1);
            chk("halt_no_req", imem_req, 0);
            chk("halt_pc", pc, model_pc);
            imem_ack  = 1'($urandom);
            pc_load   = 1'($urandom);
            pc_target = 8'($urandom);
            ir_ready  = 1'($urandom);
            step();
         end
         imem_ack = 1'b0;
         pc_load  = 1'b0;
         ir_ready = 1'b0;
         resume   = 1'b1;
         step();
         resume   = 1'b0;
         model_pc = model_pc + 8'd1;
         chk("resume_req", imem_req, 1);
         chk("halted_clear", halted, 0);
      end else begin
         model_pc = ld ? tgt : model_pc + 8'd1;
      end
      chk("pc_after", pc, model_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] op;
      logic       exp_err;
      model_pc = RST_PC;
      repeat (3) step();
      chk("rst_imem_req", imem_req, 0);
      chk("rst_ir_valid", ir_valid, 0);
      chk("rst_ir", ir, 8'h00);
      chk("rst_pc", pc, RST_PC);
      chk("rst_halted", halted, 0);
      chk("rst_fetch_err", fetch_err, 0);

      reset = 1'b1;
      chk("idle_no_req", imem_req, 0);
      fetch_one(8'h13, 0, 0, 1'b0, 8'h00, 1);
      fetch_one(8'h75, 1, 2, 1'b1, 8'h40, 1);
      fetch_one(8'h22, 3, 0, 1'b0, 8'h00, 1);
      fetch_one(8'h01, 0, 0, 1'b1, 8'h04, 1);
      fetch_one(8'h10, 0, 0, 1'b0, 8'h00, 1);
      fetch_one(8'hF0, 0, 0, 1'b0, 8'h00, 10);
      fetch_one(8'h30, 0, 0, 1'b1, 8'hFF, 1);
      fetch_one(8'h31, 0, 0, 1'b0, 8'h00, 1);
      fetch_one(8'h44, 0, 5, 1'b0, 8'h00, 1);

      for (int k = 0; k < 150; k++) begin
         op = 8'($urandom);
         fetch_one(op, $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), 8'($urandom), $urandom_range(1, 4));
      end

      addr_q.push_back(model_pc);
      while (!imem_req) step();
      for (int k = 0; k <= 20; k++) begin
`ifdef FETCH_TIMEOUT_EN
         exp_err = (k >= TOUT);
`else
         exp_err = 1'b0;
`endif
         chk("timeout_err", fetch_err, exp_err);
         chk("timeout_req", imem_req, !exp_err);
         step();
      end

      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_req", imem_req, 0);
      chk("async_rst_pc", pc, RST_PC);
      chk("async_rst_err", fetch_err, 0);
      imem_ack  = 1'b1;
      imem_data = 8'hAA;
      step();
      step();
      chk("rst_hold_req", imem_req, 0);
      reset    = 1'b1;
      model_pc = RST_PC;
      step();
      imem_ack = 1'b0;
      fetch_one(8'h13, 1, 0, 1'b0, 8'h00, 1);

      addr_q.push_back(model_pc);
      step();
      step();
      chk("addr_q_drained", addr_q.size(), 0);
      chk("ir_q_drained", ir_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 15, legal range 1..255, giving the maximum imem_ack wait in cycles.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port imem_req, output, 1, instruction memory read request.
REQ-006 The block SHALL have port imem_addr, output, 8, read address, equal to pc.
REQ-007 The block SHALL have ports imem_ack, input, 1, and imem_data, input, 8: read done, and opcode valid while imem_ack=1.
REQ-008 The block SHALL have ports ir, output, 8, and ir_valid, output, 1: the held opcode and its valid flag.
REQ-009 The block SHALL have port ir_ready, input, 1, asserted by the controller to accept ir.
REQ-010 The block SHALL have ports pc_load, input, 1, and pc_target, input, 8: jump taken and jump destination.
REQ-011 The block SHALL have ports pc, output, 8, halted, output, 1, and resume, input, 1: program counter, HALT-state flag, and restart request.
REQ-012 The block SHALL have port fetch_err, output, 1, asserted in the ERR state.

Function
REQ-013 The block SHALL implement states IDLE, REQ, HOLD, HALT and ERR.
REQ-014 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-015 In REQ, imem_req SHALL be 1; on imem_ack=1, ir SHALL capture imem_data and the state SHALL go to HOLD in the same edge.
REQ-016 imem_req SHALL be 0 in every state other than REQ; imem_ack outside REQ SHALL be ignored.
REQ-017 In HOLD, ir_valid SHALL be 1 and ir SHALL remain stable until the cycle in which ir_ready=1; ir_valid SHALL be 0 in all other states.
REQ-018 On acceptance (HOLD and ir_ready=1), if ir[7:4]=4'b1111 the next state SHALL be HALT and pc SHALL be unchanged; pc_load SHALL be ignored.
REQ-019 On acceptance of a non-HALT opcode, pc SHALL become pc_target if pc_load=1, else pc+1 modulo 256, and the next state SHALL be REQ.
REQ-020 pc_load SHALL be ignored in every cycle other than an acceptance cycle.
REQ-021 PC SHALL wrap 8'hFF -> 8'h00 with no flag or stall.
REQ-022 In HALT, halted SHALL be 1; on resume=1, pc SHALL become pc+1 and the state SHALL go to REQ. Any other input in HALT SHALL be ignored.
REQ-023 Minimum fetch latency SHALL be 1 cycle from imem_req rise to ir_valid rise when imem_ack is returned in the first REQ cycle.
REQ-024 Back-to-back throughput SHALL be one instruction per 2 cycles: REQ with immediate ack, then HOLD with immediate ready.

Reset
REQ-025 While reset=0, outputs SHALL be: imem_req=0, ir_valid=0, ir=8'h00, pc=RESET_PC, halted=0, fetch_err=0, state=IDLE, timeout counter=0.
REQ-026 Reset assertion SHALL take effect without a clock edge, aborting any outstanding request; a later imem_ack for it SHALL be ignored.

Configuration
REQ-027 With macro FETCH_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to REQ and increment each REQ cycle without ack. On reaching TIMEOUT_CYCLES, the state SHALL go to ERR with fetch_err=1 and imem_req=0. ERR SHALL be left only by reset.
REQ-028 Without FETCH_TIMEOUT_EN, no counter SHALL exist, REQ SHALL wait indefinitely, ERR SHALL be unreachable, and fetch_err SHALL be tied to 0.

Verification
REQ-029 Reset release, imem_ack same cycle with data 8'h13, ir_ready=1 -> imem_addr=00, ir=13 valid one cycle, pc=01, next imem_req at addr 01.
REQ-030 Opcode 8'h75 accepted with pc_load=1, pc_target=8'h40 -> pc=40, next imem_addr=40. Then pc_load=1 pulsed during REQ -> pc unaffected.
REQ-031 Opcode 8'hF0 at pc=05 accepted -> halted=1, pc stays 05, no imem_req for 10 cycles. Then resume=1 -> pc=06, imem_req=1.
REQ-032 pc=FF, non-jump opcode accepted -> pc=00, imem_addr=00.
REQ-033 ir_valid held with ir_ready=0 for 5 cycles while imem_data toggles -> ir stable, imem_req=0. Reset pulsed during REQ -> imem_req drops asynchronously and pc=RESET_PC.
REQ-034 With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=15, no ack -> fetch_err=1 after 15 REQ cycles and stays set. Without the macro, same stimulus -> imem_req held, fetch_err=0.
